// File: rtl/mp_pkg.sv
// Shared package for the multi-core processor slice.
//
// Contents:
//   - FSM state encodings for the data-memory arbiter (IDLE/ISSUE/DATA)
//   - core index constants CORE_A..CORE_D = 0..3
//   - core-select bit weights used by the instruction encoding
//   - small helpers for converting a core index to a one-hot or weight
package mp_pkg;

  localparam int NUM_CORES = 4;

  typedef logic [1:0] core_idx_t;

  // Arbiter FSM encoding. Kept as plain constants so older code that
  // compares against raw 2-bit values keeps working.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam core_idx_t CORE_A = 2'd0;
  localparam core_idx_t CORE_B = 2'd1;
  localparam core_idx_t CORE_C = 2'd2;
  localparam core_idx_t CORE_D = 2'd3;

  // Core-select bit weights as they appear in the instruction word.
  localparam int unsigned CORE_SEL_A = 32'd4096;
  localparam int unsigned CORE_SEL_B = 32'd8192;
  localparam int unsigned CORE_SEL_C = 32'd16384;
  localparam int unsigned CORE_SEL_D = 32'd32768;

  // One-hot vector for a core index (bit 0 = core a).
  function automatic logic [NUM_CORES-1:0] core_onehot(input core_idx_t idx);
    core_onehot = 4'b0001 << idx;
  endfunction

  // Instruction-encoding weight for a core index.
  function automatic logic [15:0] core_sel_weight(input core_idx_t idx);
    core_sel_weight = 16'h1000 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4 -- combinational 4-way round-robin picker.
//
// The search starts at the core after last_winner and wraps a->b->c->d->a,
// so the most recent winner has the lowest priority for the next pick.
//
// Ports:
//   eligible     in   4  request mask, bit 0 = core a
//   last_winner  in   2  index of the most recently served core
//   valid        out  1  at least one eligible core
//   winner       out  2  chosen core index (0 when valid is low)
module rr_pick4
  import mp_pkg::*;
(
  input  logic [NUM_CORES-1:0] eligible,
  input  core_idx_t            last_winner,
  output logic                 valid,
  output core_idx_t            winner
);

  core_idx_t             start;
  logic [NUM_CORES-1:0]  rot;
  core_idx_t             off;

  always_comb begin
    start = last_winner + 2'd1;
    // Rotate the mask so bit 0 is the first core to consider; a fixed
    // priority encoder on the rotated mask then gives the round-robin order.
    rot   = 4'({eligible, eligible} >> start);
    valid = |eligible;
    off   = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    // Undo the rotation; 2-bit addition wraps modulo 4.
    winner = valid ? core_idx_t'(start + off) : CORE_A;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- round-robin arbiter sharing the single-port, synchronous-
// read data memory among cores a..d.
//
// Every access takes exactly three cycles: IDLE (pick) -> ISSUE (memory
// acts on the closing edge) -> DATA (read data valid, done registered on
// the closing edge) -> IDLE. There are no back-to-back ISSUE states.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   req_x / we_x / addr_x /
//   wdata_x  (x = a..d)          per-core request, held until its done
//   grant_x                      registered one-hot, high in ISSUE and DATA
//   done_x                       registered one-cycle completion pulse
//   rdata_x                      registered load data, held until next done
//   mem_addr / mem_wdata / mem_we   data-memory request port
//   mem_rdata                    data-memory read data (one cycle latency)
//   busy                         high in ISSUE and DATA
module dmem_arbiter
  import mp_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req_a,
  input  logic              req_b,
  input  logic              req_c,
  input  logic              req_d,
  input  logic              we_a,
  input  logic              we_b,
  input  logic              we_c,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W-1:0] wdata_c,
  input  logic [DATA_W-1:0] wdata_d,

  output logic              grant_a,
  output logic              grant_b,
  output logic              grant_c,
  output logic              grant_d,
  output logic              done_a,
  output logic              done_b,
  output logic              done_c,
  output logic              done_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] rdata_d,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  logic [1:0]            state_q;
  core_idx_t             last_q;
  core_idx_t             win_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NUM_CORES-1:0]  grant_q;
  logic [NUM_CORES-1:0]  done_q;
  logic [DATA_W-1:0]     rdata_q [NUM_CORES];

  logic [NUM_CORES-1:0]  req_v;
  logic [NUM_CORES-1:0]  eligible;
  logic                  pick_valid;
  core_idx_t             pick_idx;
  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  take;

  assign req_v = {req_d, req_c, req_b, req_a};

  // A core whose done is visible this cycle is still holding req (it drops
  // it in this same cycle), so mask it to avoid granting a stale request.
  assign eligible = req_v & ~done_q;

  rr_pick4 u_pick (
    .eligible    (eligible),
    .last_winner (last_q),
    .valid       (pick_valid),
    .winner      (pick_idx)
  );

  assign take = (state_q == IDLE) && pick_valid;

  // Winner's request fields; only the winner's signals are ever looked at.
  always_comb begin
    sel_we    = we_a;
    sel_addr  = addr_a;
    sel_wdata = wdata_a;
    case (pick_idx)
      CORE_B: begin
        sel_we    = we_b;
        sel_addr  = addr_b;
        sel_wdata = wdata_b;
      end
      CORE_C: begin
        sel_we    = we_c;
        sel_addr  = addr_c;
        sel_wdata = wdata_c;
      end
      CORE_D: begin
        sel_we    = we_d;
        sel_addr  = addr_d;
        sel_wdata = wdata_d;
      end
      default: begin
        sel_we    = we_a;
        sel_addr  = addr_a;
        sel_wdata = wdata_a;
      end
    endcase
  end

  // ---- Control: FSM, grant, done, round-robin pointer ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= CORE_D;
      win_q   <= CORE_A;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win_q   <= pick_idx;
            grant_q <= core_onehot(pick_idx);
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= DATA;
        end
        DATA: begin
          done_q  <= core_onehot(win_q);
          last_q  <= win_q;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // ---- Request capture: winner's we/addr/wdata held for ISSUE ----
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // ---- Response: load data returned to the winner at the end of DATA ----
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        rdata_q[i] <= '0;
      end
    end else if ((state_q == DATA) && !we_q) begin
      rdata_q[win_q] <= mem_rdata;
    end
  end

  // Gating with reset kills a store whose ISSUE cycle coincides with reset,
  // since the memory would otherwise act on that same edge.
  assign mem_we    = (state_q == ISSUE) & we_q & ~reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  assign grant_a = grant_q[CORE_A];
  assign grant_b = grant_q[CORE_B];
  assign grant_c = grant_q[CORE_C];
  assign grant_d = grant_q[CORE_D];

  assign done_a  = done_q[CORE_A];
  assign done_b  = done_q[CORE_B];
  assign done_c  = done_q[CORE_C];
  assign done_d  = done_q[CORE_D];

  assign rdata_a = rdata_q[CORE_A];
  assign rdata_b = rdata_q[CORE_B];
  assign rdata_c = rdata_q[CORE_C];
  assign rdata_d = rdata_q[CORE_D];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter and its rr_pick4 picker.
module tb_dmem_arbiter;
  import mp_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req_v = 4'b0;
  logic [3:0]        we_v  = 4'b0;
  logic [ADDR_W-1:0] addr_v  [4];
  logic [DATA_W-1:0] wdata_v [4];

  logic [3:0]        grant_o;
  logic [3:0]        done_o;
  logic [DATA_W-1:0] rdata_o [4];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  logic [3:0]        pk_elig = 4'b0;
  logic [1:0]        pk_last = 2'd0;
  logic              pk_valid;
  logic [1:0]        pk_idx;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_v[0]), .req_b(req_v[1]), .req_c(req_v[2]), .req_d(req_v[3]),
    .we_a(we_v[0]), .we_b(we_v[1]), .we_c(we_v[2]), .we_d(we_v[3]),
    .addr_a(addr_v[0]), .addr_b(addr_v[1]), .addr_c(addr_v[2]), .addr_d(addr_v[3]),
    .wdata_a(wdata_v[0]), .wdata_b(wdata_v[1]), .wdata_c(wdata_v[2]), .wdata_d(wdata_v[3]),
    .grant_a(grant_o[0]), .grant_b(grant_o[1]), .grant_c(grant_o[2]), .grant_d(grant_o[3]),
    .done_a(done_o[0]), .done_b(done_o[1]), .done_c(done_o[2]), .done_d(done_o[3]),
    .rdata_a(rdata_o[0]), .rdata_b(rdata_o[1]), .rdata_c(rdata_o[2]), .rdata_d(rdata_o[3]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  rr_pick4 u_pick (
    .eligible(pk_elig), .last_winner(pk_last), .valid(pk_valid), .winner(pk_idx)
  );

  // Memory contents before any store.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 16'd4) return 16'd1;
    return 16'(a * 16'd3 + 16'd1);
  endfunction

  // Synchronous-read single-port memory seen by the DUT.
  logic [DATA_W-1:0] phys [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] mem_peek(input logic [ADDR_W-1:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  always @(posedge clock) begin
    mem_rdata <= mem_peek(mem_addr);
    if (mem_we) phys[mem_addr] = mem_wdata;
  end

  // ---------------- reference model (transaction level) ----------------
  logic [DATA_W-1:0] gold [logic [ADDR_W-1:0]];
  bit                m_active, m_issue, m_we;
  int                m_start, m_win, m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        e_done, e_grant;
  logic              e_busy;
  logic [DATA_W-1:0] e_rdata [4];

  function automatic logic [DATA_W-1:0] gold_rd(input logic [ADDR_W-1:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // Core with the smallest forward distance from the last winner.
  function automatic int rr_model(input logic [3:0] elig, input int last);
    int best  = -1;
    int bestd = 99;
    for (int c = 0; c < 4; c++) begin
      if (elig[c]) begin
        int d;
        d = (c - last + 3) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_active = 0; m_issue = 0; m_we = 0; m_win = 0; m_last = 3; m_start = 0;
    m_addr = '0; m_wdata = '0;
    e_done = '0; e_grant = '0; e_busy = 1'b0;
    for (int c = 0; c < 4; c++) e_rdata[c] = '0;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [3:0] prev_done;
    int w;
    if (reset) begin
      model_reset();
      return;
    end
    prev_done = e_done;
    e_done = '0;
    if (m_active) begin
      if (edge_n == m_start + 1) begin
        m_issue = 0;
      end else if (edge_n == m_start + 2) begin
        if (m_we) gold[m_addr] = m_wdata;
        else      e_rdata[m_win] = gold_rd(m_addr);
        e_done[m_win] = 1'b1;
        e_grant  = '0;
        e_busy   = 1'b0;
        m_last   = m_win;
        m_active = 0;
      end
    end else begin
      w = rr_model(req_v & ~prev_done, m_last);
      if (w >= 0) begin
        m_active = 1; m_issue = 1; m_start = edge_n; m_win = w;
        m_we = we_v[w]; m_addr = addr_v[w]; m_wdata = wdata_v[w];
        e_grant = 4'(1 << w);
        e_busy  = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, expv, edge_n);
    end
  endtask

  task automatic check_outputs();
    chk("done", 32'(done_o), 32'(e_done));
    chk("grant", 32'(grant_o), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_we", 32'(mem_we), 32'(m_issue & m_we & !reset));
    if (m_issue) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    for (int c = 0; c < 4; c++) chk("rdata", 32'(rdata_o[c]), 32'(e_rdata[c]));
  endtask

  task automatic tick();
    @(posedge clock);
    edge_n++;
    model_edge();
    #1;
    check_outputs();
  endtask

  // Run n cycles; requesters drop req in their done cycle and do not re-raise.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int c = 0; c < 4; c++) if (e_done[c]) req_v[c] = 1'b0;
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(3) == 0) return 16'(16'hFFFF - 16'($urandom_range(3)));
    return 16'($urandom_range(15));
  endfunction

  int          n_we, cidx, prev, served, lat;
  int          ev_core[$];
  int          ev_cyc[$];
  int          raise_edge [4];
  int          exp_core [5] = '{0, 1, 2, 3, 0};
  int          exp_cyc  [5] = '{3, 6, 9, 12, 15};

  initial begin
    for (int c = 0; c < 4; c++) begin
      addr_v[c] = '0; wdata_v[c] = '0; raise_edge[c] = 0;
    end
    model_reset();

    // Picker standalone: every mask for every last_winner.
    for (int l = 0; l < 4; l++) begin
      for (int m = 0; m < 16; m++) begin
        pk_last = 2'(l);
        pk_elig = 4'(m);
        #1;
        chk("pick_valid", 32'(pk_valid), 32'(m != 0));
        if (m != 0) chk("pick_idx", 32'(pk_idx), 32'(rr_model(4'(m), l)));
      end
    end

    // Reset state.
    reset = 1'b1;
    tick(); tick();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b0;
    tick();

    // Single load by core b from address 2.
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 16'd2;
    tick(); chk("ld_grant_c1", 32'(grant_o), 32'h2);
    tick(); chk("ld_grant_c2", 32'(grant_o), 32'h2);
    tick(); chk("ld_done_c3", 32'(done_o), 32'h2);
    chk("ld_rdata_b", 32'(rdata_o[1]), 32'd7);
    req_v[1] = 1'b0;
    tick(); chk("ld_done_clear", 32'(done_o), 0);

    // Store 55 to address 9 by core a, then load it back.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd9; wdata_v[0] = 16'd55;
    n_we = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_we) begin
        n_we++;
        chk("st_mem_addr", 32'(mem_addr), 32'd9);
      end
    end
    chk("st_we_cycles", 32'(n_we), 32'd1);
    chk("st_done_a", 32'(done_o), 32'h1);
    req_v[0] = 1'b0;
    tick();
    req_v[0] = 1'b1; we_v[0] = 1'b0;
    tick(); tick(); tick();
    chk("ld_after_st_done", 32'(done_o), 32'h1);
    chk("ld_after_st_data", 32'(rdata_o[0]), 32'd55);
    req_v[0] = 1'b0;
    tick();

    // Full contention right after reset; core a re-requests once.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_v[c] = 1'b1; we_v[c] = 1'b0; addr_v[c] = 16'(10 + c);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (done_o[c]) begin
          ev_core.push_back(c);
          ev_cyc.push_back(k);
        end
        if (e_done[c]) req_v[c] = 1'b0;
      end
      if (k == 4) req_v[0] = 1'b1;
    end
    chk("cont_count", 32'(ev_core.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < ev_core.size()) begin
        chk("cont_order", 32'(ev_core[i]), 32'(exp_core[i]));
        chk("cont_cycle", 32'(ev_cyc[i]), 32'(exp_cyc[i]));
      end
    end
    drain(6);

    // Fairness: a and c request continuously.
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'd20;
    req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 16'd21;
    prev = -1; served = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      cidx = -1;
      for (int c = 0; c < 4; c++) if (done_o[c]) cidx = c;
      if (cidx >= 0) begin
        served++;
        chk("fair_member", 32'(cidx == 0 || cidx == 2), 32'd1);
        chk("fair_no_repeat", 32'(cidx == prev), 32'd0);
        prev = cidx;
      end
      req_v[0] = !e_done[0];
      req_v[2] = !e_done[2];
    end
    chk("fair_count", 32'(served), 32'd8);
    drain(8);

    // Done masking: core d keeps req high during its done cycle.
    req_v[3] = 1'b1; we_v[3] = 1'b0; addr_v[3] = 16'd30;
    tick(); tick(); tick();
    chk("mask_done_d", 32'(done_o), 32'h8);
    tick();
    chk("mask_no_grant", 32'(grant_o), 0);
    chk("mask_idle", 32'(busy), 0);
    req_v[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mask_no_regrant", 32'(grant_o[3]), 0);
    end

    // Reset during the ISSUE cycle of a store.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd4; wdata_v[0] = 16'h1234;
    tick();
    chk("rst_st_issue", 32'(mem_we), 32'd1);
    reset = 1'b1; req_v[0] = 1'b0;
    #1;
    chk("rst_st_we_gated", 32'(mem_we), 0);
    tick();
    reset = 1'b0;
    chk("rst_st_grant", 32'(grant_o), 0);
    chk("rst_st_busy", 32'(busy), 0);
    chk("rst_st_addr", 32'(mem_addr), 0);
    chk("rst_st_wdata", 32'(mem_wdata), 0);
    for (int c = 0; c < 4; c++) chk("rst_st_rdata", 32'(rdata_o[c]), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_st_no_done", 32'(done_o), 0);
    end
    chk("rst_st_mem4", 32'(mem_peek(16'd4)), 32'd1);
    req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 16'd4;
    tick(); tick(); tick();
    chk("rst_next_done", 32'(done_o), 32'h4);
    chk("rst_next_rdata", 32'(rdata_o[2]), 32'd1);
    req_v[2] = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (done_o[c]) begin
          lat = edge_n - raise_edge[c] + 1;
          chk("wait_bound", 32'(lat <= 12), 32'd1);
        end
        if (req_v[c]) begin
          if (e_done[c]) begin
            req_v[c] = 1'b0;
          end else if (!(m_active && m_win == c) && $urandom_range(3) == 0) begin
            we_v[c] = 1'($urandom_range(1));
            addr_v[c] = rand_addr();
            wdata_v[c] = 16'($urandom);
          end
        end else if ($urandom_range(2) == 0) begin
          req_v[c] = 1'b1;
          we_v[c] = 1'($urandom_range(1));
          addr_v[c] = rand_addr();
          wdata_v[c] = 16'($urandom);
          raise_edge[c] = edge_n + 1;
        end
      end
    end
    drain(15);
    chk("final_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
